// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states and default frame width.
// No logic, so no latency; flow control lives in the modules that import this package.
// The round-robin pointer increment wraps explicitly, so non-power-of-two requester counts work.
package uart_pkg;

    localparam int DBIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first set bit of req at or above ptr, wrapping past N_REQ-1.
// Purely combinational, zero latency; ptr must lie in 0..N_REQ-1.
// No flow control of its own; the caller decides when a grant is taken.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     gnt_valid,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);

    localparam int IW = $clog2(N_REQ);

    int            w_idx;
    logic [IW-1:0] w_pos;

    // Scan downward so the smallest offset from ptr is the last one written and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = 0;
        w_pos     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_pos = IW'(w_idx);
            if (req[w_pos]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_pos;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte sources in round-robin order; optional watchdog under UART_TX_SCHED_TIMEOUT_EN.
// Latency: req_ready is combinational in IDLE, tx_start follows the handshake by one cycle.
// Backpressure: at most one frame in flight; req_ready stays low until tx_done_tick (or watchdog expiry) returns to IDLE.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DBIT           = DBIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DBIT-1:0]    req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [DBIT-1:0]          tx_din,
    input  logic                     tx_done_tick,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int IW = $clog2(N_REQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_grant_id;
    logic [DBIT-1:0] r_tx_din;

    logic            w_gnt_valid;
    logic [IW-1:0]   w_gnt_idx;
    logic [DBIT-1:0] w_sel_dat;
    logic            w_grant;
    logic            w_frame_end;
    logic            w_tx_start;
    logic            w_wd_expire;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .req      (req_valid),
        .ptr      (r_rr_ptr),
        .gnt_valid(w_gnt_valid),
        .gnt_idx  (w_gnt_idx)
    );

    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == IW'(i)) begin
                w_sel_dat = req_data[i*DBIT +: DBIT];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A done pulse outranks watchdog expiry when both land in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_frame_end = 1'b0;
        w_tx_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_tx_start  = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done_tick || w_wd_expire) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are masked by rst so an aborted frame never leaks a start or a handshake.
    always_comb begin
        req_ready = '0;
        if (w_grant && !rst) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign tx_start = w_tx_start && !rst;
    assign tx_din   = r_tx_din;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_tx_din   <= '0;
        end else begin
            if (w_grant) begin
                r_grant_id <= w_gnt_idx;
                r_tx_din   <= w_sel_dat;
            end
            if (w_frame_end) begin
                r_rr_ptr <= IW'(wrap_inc(int'(r_grant_id), N_REQ));
            end
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wd_cnt;
    logic          r_err_timeout;

    assign w_wd_expire = (r_state == WAIT) && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    // START always precedes WAIT, so clearing there gives a zero count on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_wd_expire && !tx_done_tick;
            if (r_state == START) begin
                r_wd_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: randomized requesters and transmitter against a frame-level round-robin model.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int TO = 16;
    localparam int VW = 1 + N + 1 + 1 + DW + IW;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic            tx_done_tick;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DW-1:0]   tx_din;
    logic [IW-1:0]   grant_id;
    logic            busy;
    logic            err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ         (N),
        .DBIT          (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done_tick(tx_done_tick),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // Round-robin rule: first valid index at or after the pointer, modulo N.
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tx_done_tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic add_requests(input logic [N-1:0] extra);
        for (int i = 0; i < N; i++) begin
            if (extra[i] && !req_valid[i]) begin
                req_data[i*DW +: DW] = DW'($urandom);
                req_valid[i] = 1'b1;
            end
        end
    endtask

    // One frame, entered just after the edge that opens an IDLE cycle; returns just after the edge opening the next IDLE cycle.
    task automatic run_frame(input int delay, input logic [N-1:0] extra, input bit refill,
                             input bit done_in_start, input bit no_done, input string tag, output int g);
        logic [N-1:0]  er;
        logic [DW-1:0] exp_d;
        logic [VW-1:0] act;
        logic [VW-1:0] expv;
        g = model_pick(req_valid, m_ptr);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_ready, busy} !== {er, 1'b0}) begin
            n_bad++;
            $display("FAIL %s grant: req_ready/busy got %b want %b", tag, {req_ready, busy}, {er, 1'b0});
        end
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        exp_d = req_data[g*DW +: DW];
        @(posedge clk); #1;
        if (refill) req_data[g*DW +: DW] = DW'($urandom);
        else req_valid[g] = 1'b0;
        tx_done_tick = done_in_start;
        @(negedge clk);
        act  = {tx_start, req_ready, busy, err_timeout, tx_din, grant_id};
        expv = {1'b1, {N{1'b0}}, 1'b1, 1'b0, exp_d, IW'(g)};
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s start: {start,rdy,busy,err,din,gid} got %h want %h", tag, act, expv);
        end
        for (int c = 1; c <= delay; c++) begin
            @(posedge clk); #1;
            if (c == 1) add_requests(extra);
            tx_done_tick = (c == delay) && !no_done;
            @(negedge clk);
            act  = {tx_start, req_ready, busy, err_timeout, tx_din, grant_id};
            expv = {1'b0, {N{1'b0}}, 1'b1, 1'b0, exp_d, IW'(g)};
            n_cmp++;
            if (act !== expv) begin
                n_bad++;
                $display("FAIL %s wait c=%0d: {start,rdy,busy,err,din,gid} got %h want %h", tag, c, act, expv);
            end
        end
        @(posedge clk); #1;
        tx_done_tick = 1'b0;
        m_ptr = (g + 1) % N;
    endtask

    task automatic test_reset();
        logic [VW-1:0] act;
        rst = 1'b1;
        tx_done_tick = 1'b0;
        req_valid = N'($urandom) | 4'b0001;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({tx_start, req_ready} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: {start,rdy} got %b want 0", {tx_start, req_ready});
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        m_ptr = 0;
        @(negedge clk);
        act = {tx_start, req_ready, busy, err_timeout, tx_din, grant_id};
        n_cmp++;
        if (act !== '0) begin
            n_bad++;
            $display("FAIL reset_state: outputs got %h want 0", act);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int g;
        req_valid = 4'b0100;
        req_data = 32'h0;
        req_data[2*DW +: DW] = 8'h5A;
        run_frame(10, '0, 1'b0, 1'b0, 1'b0, "single", g);
    endtask

    task automatic test_all_four();
        int g;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
        do_reset();
        for (int f = 0; f < 5; f++) run_frame(10, '0, 1'b1, 1'b0, 1'b0, "all_four", g);
        req_valid = '0;
    endtask

    task automatic test_priority();
        int g;
        req_valid = '0;
        do_reset();
        add_requests(4'b0010);
        run_frame(5, 4'b0101, 1'b0, 1'b0, 1'b0, "prio_first", g);
        run_frame(3, '0, 1'b0, 1'b0, 1'b0, "prio_second", g);
        run_frame(3, '0, 1'b0, 1'b0, 1'b0, "prio_third", g);
    endtask

    task automatic test_reset_midframe();
        int g;
        logic [N-1:0] er;
        for (int variant = 0; variant < 2; variant++) begin
            req_valid = '0;
            do_reset();
            add_requests(4'b0100);
            run_frame(2, '0, 1'b0, 1'b0, 1'b0, "rmid_setup", g);
            add_requests(4'b1010);
            er = '0;
            er[model_pick(req_valid, m_ptr)] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (req_ready !== er) begin
                n_bad++;
                $display("FAIL rmid_grant v%0d: req_ready got %b want %b", variant, req_ready, er);
            end
            @(posedge clk); #1;
            req_data[3*DW +: DW] = DW'($urandom);
            if (variant == 1) begin
                repeat (3) begin @(posedge clk); #1; end
            end
            rst = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({tx_start, req_ready} !== '0) begin
                n_bad++;
                $display("FAIL rmid_abort v%0d: {start,rdy} got %b want 0", variant, {tx_start, req_ready});
            end
            @(posedge clk); #1;
            rst = 1'b0;
            m_ptr = 0;
            #3;
            n_cmp++;
            if ({busy, tx_start, grant_id, tx_din} !== '0) begin
                n_bad++;
                $display("FAIL rmid_after v%0d: {busy,start,gid,din} got %h want 0", variant, {busy, tx_start, grant_id, tx_din});
            end
            run_frame(4, '0, 1'b0, 1'b0, 1'b0, "rmid_regrant", g);
        end
        req_valid = '0;
    endtask

    task automatic test_idle_done();
        logic [VW-1:0] act;
        int g;
        req_valid = '0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tx_done_tick = (c % 2 == 0);
            @(negedge clk);
            act = {tx_start, req_ready, busy, err_timeout, tx_din, grant_id};
            n_cmp++;
            if (act !== '0) begin
                n_bad++;
                $display("FAIL idle_done c=%0d: outputs got %h want 0", c, act);
            end
            @(posedge clk); #1;
        end
        tx_done_tick = 1'b0;
        add_requests('1);
        run_frame(3, '0, 1'b0, 1'b1, 1'b0, "idle_done_next", g);
        req_valid = '0;
    endtask

    task automatic test_random();
        int g;
        for (int f = 0; f < 30; f++) begin
            add_requests(N'($urandom));
            run_frame(int'($urandom_range(1, 8)), N'($urandom), 1'($urandom), 1'($urandom), 1'b0, "random", g);
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int g;
        req_valid = '0;
        do_reset();
`ifdef UART_TX_SCHED_TIMEOUT_EN
        add_requests(4'b0011);
        run_frame(TO, '0, 1'b0, 1'b0, 1'b1, "to_expire", g);
        #3;
        n_cmp++;
        if ({err_timeout, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL to_pulse: {err,busy} got %b want 10", {err_timeout, busy});
        end
        run_frame(3, '0, 1'b0, 1'b0, 1'b0, "to_next", g);
        add_requests(4'b0001);
        run_frame(TO, '0, 1'b0, 1'b0, 1'b0, "to_done_wins", g);
        #3;
        n_cmp++;
        if ({err_timeout, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL to_done_wins: {err,busy} got %b want 00", {err_timeout, busy});
        end
`else
        add_requests(4'b0001);
        run_frame(3 * TO, '0, 1'b0, 1'b0, 1'b0, "no_wd", g);
        #3;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL no_wd_err: err_timeout got %b want 0", err_timeout);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        tx_done_tick = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_priority();
        test_reset_midframe();
        test_idle_done();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
